reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Sequences power-up and recovery resets for the clock-manager IP.
- Pulses the MMCM reset, waits for the lock to be stable, then releases per-domain resets in a fixed order with a programmable gap between each.
- Restarts the whole sequence on lock loss, lock timeout or a software reset request.
- Its per-domain outputs feed the downstream per-domain reset synchronisers.

Parameters:
NUM_DOMAINS, 4, number of downstream reset domains (>=1); index 0 released first
MMCM_RST_CYCLES, 16, cycles mmcm_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 256, consecutive synced-lock cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max WAIT_LOCK cycles before retry (>=2)
RELEASE_GAP, 8, cycles between successive domain releases (>=1)

Ports:
clk  input  1  system clock; sole clock
rst  input  1  synchronous, active-low reset
mmcm_locked  input  1  MMCM lock, asynchronous; 2-flop synchronised internally
sw_rst_req  input  1  single-cycle synchronous restart request
mmcm_rst  output  1  active-high MMCM reset
domain_rst_n  output  NUM_DOMAINS  active-low domain resets
seq_done  output  1  high while all domains are released (RUN)
lock_lost  output  1  one-cycle pulse on lock loss during RELEASE or RUN
lock_fail  output  1  one-cycle pulse on WAIT_LOCK timeout
retry_cnt  output  8  saturating count of timeouts plus lock losses
state  output  3  encoding: 0 MMCM_RST, 1 WAIT_LOCK, 2 LOCK_STABLE, 3 RELEASE, 4 RUN

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset: sampled rst==0 at a clk edge forces the following.
  - state=MMCM_RST, internal counter=0, domain index=0.
  - mmcm_rst=1, domain_rst_n=all 0, seq_done=0, lock_lost=0, lock_fail=0, retry_cnt=0.
  - Synchroniser flops are cleared to 0.
  - Reset mid-sequence aborts immediately to these values.
- locked_s is mmcm_locked after 2 flops (2-cycle latency). Only locked_s is used in decisions.
- MMCM_RST:
  - mmcm_rst=1 and domain_rst_n=0 for exactly MMCM_RST_CYCLES cycles (counting from the first edge with rst=1).
  - Then go to WAIT_LOCK; mmcm_rst=0 from that cycle.
- WAIT_LOCK:
  - If locked_s=1: go to LOCK_STABLE with counter=0.
  - Else if counter==LOCK_TIMEOUT_CYCLES-1: lock_fail pulses, retry_cnt+1 (saturates at 255), go to MMCM_RST.
- LOCK_STABLE:
  - locked_s must stay 1 for LOCK_STABLE_CYCLES consecutive cycles, then go to RELEASE.
  - If locked_s=0 at any point: return to WAIT_LOCK with counter=0. No pulse, no retry increment, timeout restarts.
- RELEASE:
  - domain_rst_n[0] goes 1 on the first RELEASE cycle.
  - domain_rst_n[i] goes 1 exactly RELEASE_GAP cycles after domain_rst_n[i-1].
  - Released bits stay 1.
  - On the cycle domain_rst_n[NUM_DOMAINS-1] goes 1: seq_done=1 and state=RUN.
  - With NUM_DOMAINS=1, go straight to RUN on the first RELEASE cycle.
- RUN: holds all outputs until a restart event.
- Lock loss (locked_s=0 in RELEASE or RUN), applied next edge:
  - domain_rst_n=all 0, seq_done=0, lock_lost pulses, retry_cnt+1 (saturating), go to MMCM_RST with counter=0.
- sw_rst_req=1 in any state except MMCM_RST:
  - Same as lock loss but without the lock_lost pulse or retry increment.
  - Ignored in MMCM_RST; the counter is not restarted.
- Simultaneous lock loss and sw_rst_req: one restart; lock_lost still pulses; retry_cnt increments once.
- Counter width is ceil(log2(max(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, MMCM_RST_CYCLES, RELEASE_GAP)))+1.
- The counter is zeroed on every state transition and never wraps within a state.
- Domain resets are never released in any order other than 0..NUM_DOMAINS-1. No domain is released while mmcm_rst=1.

Test Plan:
1. Defaults, mmcm_locked=1 from time 0, rst released at cycle 0 -> mmcm_rst high cycles 1-16; LOCK_STABLE 256 cycles; domain_rst_n rises 0x1, 0x3, 0x7, 0xF at 8-cycle spacing; seq_done rises with bit 3; retry_cnt=0.
2. LOCK_TIMEOUT_CYCLES=64, mmcm_locked=0 forever -> lock_fail pulses every 16+64 cycles; mmcm_rst re-pulses 16 cycles each time; retry_cnt counts 1, 2, 3...; saturates at 255 after 255 timeouts.
3. In RUN, drop mmcm_locked for 1 cycle -> 2+1 cycles later domain_rst_n=0x0, seq_done=0, lock_lost=1 for one cycle, state=0, retry_cnt=1; full sequence repeats.
4. In LOCK_STABLE at count 100, glitch lock low 3 cycles -> state returns to 1, no lock_lost, retry_cnt unchanged; release occurs 256 cycles after lock returns.
5. sw_rst_req in RELEASE after 0x3 released -> next edge domain_rst_n=0x0, state=0, retry_cnt unchanged; sw_rst_req during MMCM_RST -> mmcm_rst still 16 cycles total.
6. Assert rst low mid-RELEASE, and issue lock loss plus sw_rst_req together in RUN -> reset values immediately; single restart, lock_lost=1, retry_cnt+1 exactly once.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer: pulses the MMCM reset, qualifies lock,
// then releases the domain resets in index order with a fixed gap.
module reset_sequencer #(
  parameter int NUM_DOMAINS         = 4,
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_GAP         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mmcm_locked,
  input  logic                   sw_rst_req,
  output logic                   mmcm_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_done,
  output logic                   lock_lost,
  output logic                   lock_fail,
  output logic [7:0]             retry_cnt,
  output logic [2:0]             state
);

  localparam int MAX_A   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (MMCM_RST_CYCLES > RELEASE_GAP) ? MMCM_RST_CYCLES : RELEASE_GAP;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MR_LAST  = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_MMCM_RST    = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_RELEASE     = 3'd3,
    S_RUN         = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   lost_q, lost_d;
  logic                   fail_q, fail_d;
  logic [7:0]             retry_q, retry_d;
  logic                   mmcm_rst_q;
  logic [1:0]             sync_q;
  logic                   locked_s;
  logic                   restart;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    lost_d  = 1'b0;
    fail_d  = 1'b0;
    retry_d = retry_q;
    restart = 1'b0;
    case (state_q)
      S_MMCM_RST: begin
        // Restart requests are ignored here so the MMCM pulse is never shortened or stretched.
        if (cnt_q == MR_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (!locked_s && cnt_q == TO_LAST) begin
          fail_d  = 1'b1;
          retry_d = sat_inc(retry_q);
          restart = 1'b1;
        end else if (sw_rst_req) begin
          restart = 1'b1;
        end else if (locked_s) begin
          state_d = S_LOCK_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOCK_STABLE: begin
        if (sw_rst_req) begin
          restart = 1'b1;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) begin
          dom_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IDX_W'(1);
          if (NUM_DOMAINS == 1) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          lost_d  = 1'b1;
          retry_d = sat_inc(retry_q);
          restart = 1'b1;
        end else if (sw_rst_req) begin
          restart = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          lost_d  = 1'b1;
          retry_d = sat_inc(retry_q);
          restart = 1'b1;
        end else if (sw_rst_req) begin
          restart = 1'b1;
        end
      end
      default: restart = 1'b1;
    endcase
    if (restart) begin
      state_d = S_MMCM_RST;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q     <= '0;
      state_q    <= S_MMCM_RST;
      cnt_q      <= '0;
      idx_q      <= '0;
      dom_q      <= '0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      fail_q     <= 1'b0;
      retry_q    <= 8'd0;
      mmcm_rst_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], mmcm_locked};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dom_q      <= dom_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      fail_q     <= fail_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= (state_d == S_MMCM_RST);
    end
  end

  assign mmcm_rst     = mmcm_rst_q;
  assign domain_rst_n = dom_q;
  assign seq_done     = done_q;
  assign lock_lost    = lost_q;
  assign lock_fail    = fail_q;
  assign retry_cnt    = retry_q;
  assign state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized lock/request
// traffic, all checked every cycle against a phase/elapsed-time reference model.
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int MR  = 5;
  localparam int ST  = 12;
  localparam int TO  = 20;
  localparam int GAP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         mmcm_locked;
  logic         sw_rst_req;
  logic         mmcm_rst;
  logic [N-1:0] domain_rst_n;
  logic         seq_done;
  logic         lock_lost;
  logic         lock_fail;
  logic [7:0]   retry_cnt;
  logic [2:0]   state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS(N), .MMCM_RST_CYCLES(MR), .LOCK_STABLE_CYCLES(ST),
    .LOCK_TIMEOUT_CYCLES(TO), .RELEASE_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .mmcm_locked(mmcm_locked), .sw_rst_req(sw_rst_req),
    .mmcm_rst(mmcm_rst), .domain_rst_n(domain_rst_n), .seq_done(seq_done),
    .lock_lost(lock_lost), .lock_fail(lock_fail), .retry_cnt(retry_cnt), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0..4, time spent in phase, time since first release.
  int m_phase = 0;
  int m_t     = 0;
  int m_rel   = 0;
  int m_retry = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0;
  bit m_lost = 1'b0, m_fail = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_mask();
    int m;
    m = 0;
    if (m_phase >= 3)
      for (int i = 0; i < N; i++)
        if (m_phase == 4 || i * GAP <= m_rel) m = m | (1 << i);
    return m;
  endfunction

  task automatic m_restart();
    m_phase = 0;
    m_t     = 0;
    m_rel   = 0;
  endtask

  task automatic m_bump();
    if (m_retry < 255) m_retry++;
  endtask

  task automatic model_edge();
    bit ls;
    ls     = m_s2;
    m_lost = 1'b0;
    m_fail = 1'b0;
    if (!rst) begin
      m_restart();
      m_retry = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = mmcm_locked;
    case (m_phase)
      0: if (m_t == MR - 1) begin m_phase = 1; m_t = 0; end else m_t++;
      1: begin
        if (!ls && m_t == TO - 1) begin m_fail = 1'b1; m_bump(); m_restart(); end
        else if (sw_rst_req) m_restart();
        else if (ls) begin m_phase = 2; m_t = 0; end
        else m_t++;
      end
      2: begin
        if (sw_rst_req) m_restart();
        else if (!ls) begin m_phase = 1; m_t = 0; end
        else if (m_t == ST - 1) begin m_rel = 0; m_t = 0; m_phase = (N == 1) ? 4 : 3; end
        else m_t++;
      end
      default: begin
        if (!ls) begin m_lost = 1'b1; m_bump(); m_restart(); end
        else if (sw_rst_req) m_restart();
        else if (m_phase == 3) begin
          m_rel++;
          if (m_rel >= (N - 1) * GAP) m_phase = 4;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_phase));
    chk("mmcm_rst", 32'(mmcm_rst), 32'(m_phase == 0));
    chk("domain_rst_n", 32'(domain_rst_n), 32'(m_mask()));
    chk("seq_done", 32'(seq_done), 32'(m_phase == 4));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("lock_fail", 32'(lock_fail), 32'(m_fail));
    chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  task automatic run_to(input int ph, input int limit);
    for (int i = 0; i < limit && m_phase != ph; i++) step();
    chk("reach_phase", 32'(state), 32'(ph));
  endtask

  initial begin
    int r0;
    int hi_cnt;
    rst = 1'b0; mmcm_locked = 1'b1; sw_rst_req = 1'b0;
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mmcm", 32'(mmcm_rst), 32'd1);
    chk("rst_dom", 32'(domain_rst_n), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);

    // Clean power-up with lock present from the start.
    rst = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mmcm_rst) hi_cnt++;
    end
    chk("t1_mmcm_hi_cycles", 32'(hi_cnt), 32'(MR - 1));
    chk("t1_dom", 32'(domain_rst_n), 32'hF);
    chk("t1_done", 32'(seq_done), 32'd1);
    chk("t1_retry", 32'(retry_cnt), 32'd0);

    // One-cycle lock drop in RUN.
    mmcm_locked = 1'b0; step();
    mmcm_locked = 1'b1; step(); step();
    chk("t3_lost", 32'(lock_lost), 32'd1);
    chk("t3_dom", 32'(domain_rst_n), 32'd0);
    chk("t3_state", 32'(state), 32'd0);
    chk("t3_retry", 32'(retry_cnt), 32'd1);
    run_to(4, 80);

    // Lock glitch during LOCK_STABLE.
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    for (int i = 0; i < 80 && !(m_phase == 2 && m_t == 5); i++) step();
    mmcm_locked = 1'b0;
    step(); step(); step();
    mmcm_locked = 1'b1;
    chk("t4_state", 32'(state), 32'd1);
    chk("t4_lost", 32'(lock_lost), 32'd0);
    run_to(4, 80);
    chk("t4_retry", 32'(retry_cnt), 32'd1);

    // Software restart in RELEASE after two domains are out, then during MMCM_RST.
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    for (int i = 0; i < 80 && !(m_phase == 3 && m_rel >= GAP); i++) step();
    chk("t5_dom_pre", 32'(domain_rst_n), 32'h3);
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    chk("t5_dom", 32'(domain_rst_n), 32'd0);
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_retry", 32'(retry_cnt), 32'd1);
    step();
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mmcm_rst) hi_cnt++;
    end
    chk("t5_mmcm_hi_cycles", 32'(hi_cnt), 32'(MR - 3));

    // Reset mid-RELEASE, then simultaneous lock loss and software request in RUN.
    run_to(3, 80);
    rst = 1'b0; step(); rst = 1'b1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_retry", 32'(retry_cnt), 32'd0);
    chk("t6_rst_dom", 32'(domain_rst_n), 32'd0);
    run_to(4, 80);
    r0 = m_retry;
    mmcm_locked = 1'b0; step();
    mmcm_locked = 1'b1; step();
    sw_rst_req = 1'b1; step(); sw_rst_req = 1'b0;
    chk("t6_lost", 32'(lock_lost), 32'd1);
    chk("t6_retry", 32'(retry_cnt), 32'(r0 + 1));
    step();
    chk("t6_lost_clear", 32'(lock_lost), 32'd0);

    // Lock never arrives: repeated timeouts until the retry counter saturates.
    mmcm_locked = 1'b0;
    for (int i = 0; i < 258 * (MR + TO); i++) step();
    chk("t2_retry_sat", 32'(retry_cnt), 32'd255);

    // Randomized lock drops, software requests and resets.
    mmcm_locked = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (mmcm_locked) mmcm_locked = ($urandom_range(0, 299) != 0);
      else             mmcm_locked = ($urandom_range(0, 4) == 0);
      sw_rst_req = ($urandom_range(0, 399) == 0);
      rst        = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst = 1'b1; sw_rst_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
